// File: rtl/bcd_display_decoder.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : bcd_display_decoder
//  Purpose  : Drives a multiplexed 4-digit 7-segment display from four packed
//             BCD digits (MM:SS timer). One digit is scanned per slot of
//             SCAN_DIV clocks. The block supports leading-zero blanking and
//             whole-display blinking. New values are taken only at frame
//             boundaries.
//  Ports    : clk        - system clock
//             rst_n      - asynchronous active-low reset
//             load       - strobe, captures bcd_in into the shadow register
//             bcd_in     - {d3,d2,d1,d0}, d3 = most significant minute digit
//             blank_lz   - enable leading-zero blanking
//             blink_en   - enable whole-display blinking
//             seg        - segments {g,f,e,d,c,b,a}, active-high
//             dp         - decimal point, active-high
//             an         - one-hot digit enable, an[k] = digit k
//             frame_done - one-cycle pulse when the scan wraps 3 -> 0
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module bcd_display_decoder #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64,
   parameter int DP_DIGIT     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] bcd_in,
   input  logic        blank_lz,
   input  logic        blink_en,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_done
);

   localparam int                   c_PRESC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int                   c_FRM_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(SCAN_DIV - 1);
   localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);
   localparam logic [c_FRM_W-1:0]   c_FRM_MAX   = c_FRM_W'(BLINK_FRAMES - 1);
   localparam logic [c_FRM_W-1:0]   c_FRM_ONE   = c_FRM_W'(1);
   localparam logic [1:0]           c_DP_IDX    = 2'(DP_DIGIT);

   logic [c_PRESC_W-1:0] r_presc;
   logic [1:0]           r_idx;
   logic [15:0]          r_shadow;
   logic [15:0]          r_active;
   logic [c_FRM_W-1:0]   r_frm_cnt;
   logic                 r_phase;
   logic [6:0]           r_seg;
   logic                 r_dp;
   logic [3:0]           r_an;
   logic                 r_frame_done;

   logic                 w_slot_end;
   logic                 w_wrap;
   logic [1:0]           w_idx_nxt;
   logic [15:0]          w_src;
   logic [3:0]           w_digit;
   logic                 w_blank;
   logic                 w_phase_nxt;
   logic                 w_off;
   logic [6:0]           w_seg_dec;

   assign w_slot_end = (r_presc == c_PRESC_MAX);
   assign w_wrap     = w_slot_end && (r_idx == 2'd3);
   assign w_idx_nxt  = r_idx + 2'd1;

   // On the wrap edge the active register is only just being loaded, so
   // digit 0 of the new frame is decoded straight from the shadow copy.
   assign w_src = w_wrap ? r_shadow : r_active;

   always_comb begin
      w_digit = w_src[3:0];
      w_blank = 1'b0;
      case (w_idx_nxt)
         2'd0: begin
            w_digit = w_src[3:0];
            w_blank = 1'b0;
         end
         2'd1: begin
            w_digit = w_src[7:4];
            w_blank = blank_lz && (w_src[15:4] == 12'd0);
         end
         2'd2: begin
            w_digit = w_src[11:8];
            w_blank = blank_lz && (w_src[15:8] == 8'd0);
         end
         default: begin
            w_digit = w_src[15:12];
            w_blank = blank_lz && (w_src[15:12] == 4'd0);
         end
      endcase
   end

   always_comb begin
      w_seg_dec = 7'b1000000;
      case (w_digit)
         4'd0:    w_seg_dec = 7'b0111111;
         4'd1:    w_seg_dec = 7'b0000110;
         4'd2:    w_seg_dec = 7'b1011011;
         4'd3:    w_seg_dec = 7'b1001111;
         4'd4:    w_seg_dec = 7'b1100110;
         4'd5:    w_seg_dec = 7'b1101101;
         4'd6:    w_seg_dec = 7'b1111101;
         4'd7:    w_seg_dec = 7'b0000111;
         4'd8:    w_seg_dec = 7'b1111111;
         4'd9:    w_seg_dec = 7'b1101111;
         default: w_seg_dec = 7'b1000000;   // illegal code shows a dash
      endcase
   end

   // Phase that will be in force after this edge; the frame starting on a
   // wrap edge must already see a toggled phase.
   always_comb begin
      w_phase_nxt = r_phase;
      if (!blink_en) begin
         w_phase_nxt = 1'b0;
      end else if (w_wrap && (r_frm_cnt == c_FRM_MAX)) begin
         w_phase_nxt = ~r_phase;
      end
   end

   assign w_off = blink_en && w_phase_nxt;

   // Prescaler and digit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
      end else if (w_slot_end) begin
         r_presc <= '0;
         r_idx   <= w_idx_nxt;
      end else begin
         r_presc <= r_presc + c_PRESC_ONE;
      end
   end

   // Shadow captures every load; active follows shadow only at frame wrap,
   // so a same-cycle load lands one frame later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= 16'd0;
         r_active <= 16'd0;
      end else begin
         if (load) begin
            r_shadow <= bcd_in;
         end
         if (w_wrap) begin
            r_active <= r_shadow;
         end
      end
   end

   // Blink frame counter; held at zero while blinking is disabled so the
   // first half-period after enabling is always a full visible one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frm_cnt <= '0;
         r_phase   <= 1'b0;
      end else begin
         r_phase <= w_phase_nxt;
         if (!blink_en) begin
            r_frm_cnt <= '0;
         end else if (w_wrap) begin
            if (r_frm_cnt == c_FRM_MAX) begin
               r_frm_cnt <= '0;
            end else begin
               r_frm_cnt <= r_frm_cnt + c_FRM_ONE;
            end
         end
      end
   end

   // Registered display outputs, updated at each slot boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg        <= 7'd0;
         r_dp         <= 1'b0;
         r_an         <= 4'd0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_wrap;
         if (w_slot_end) begin
            if (w_off || w_blank) begin
               r_seg <= 7'd0;
               r_dp  <= 1'b0;
               r_an  <= 4'd0;
            end else begin
               r_seg <= w_seg_dec;
               r_dp  <= (w_idx_nxt == c_DP_IDX);
               r_an  <= 4'b0001 << w_idx_nxt;
            end
         end
      end
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/bcd_display_decoder.md
Name: bcd_display_decoder

Overview:
- Output-side counterpart of the keypad encoder path. It takes four packed BCD digits (MM:SS cooking timer) and drives a multiplexed 4-digit 7-segment display.
- Scans one digit per slot, decodes BCD to segments, applies leading-zero blanking and a blink mode (for "done" flashing).
- New values are applied only at frame boundaries, so a digit never shows a mix of old and new values.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (min 2)
- BLINK_FRAMES, 64, frames per blink half-period (min 1)
- DP_DIGIT, 2, digit index whose decimal point is lit (MM.SS separator)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  one-cycle strobe; capture bcd_in into shadow register
- bcd_in  input  16  digits {d3,d2,d1,d0}, d3 = most significant minute digit
- blank_lz  input  1  enable leading-zero blanking
- blink_en  input  1  enable blinking of whole display
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high
- dp  output  1  decimal point, active-high
- an  output  4  digit enable, one-hot, active-high, an[k] = digit k
- frame_done  output  1  one-cycle pulse at start of each frame

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: seg=0, dp=0, an=0, frame_done=0. Shadow register, active register, prescaler, digit index and blink counters are all 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps.
  - On the edge where prescaler==SCAN_DIV-1, the digit index advances 0→1→2→3→0.
  - All outputs are registered and reflect the new index on that same edge.
- First slot after reset: first output update occurs SCAN_DIV cycles after rst_n deasserts, showing digit index 1. The frame from index 0 is never driven; an stays 0 until then.
- Shadow/active registers:
  - load=1 → shadow ← bcd_in on the next edge. Multiple loads within a frame: the last one wins.
  - On the wrap edge 3→0, active ← shadow; digit 0 of the new frame already uses the new active value.
  - Same-cycle load and wrap: active takes the old shadow, and the new data waits for the next frame.
- Decode of active digit (segments gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Values 10–15 are illegal and display a dash (seg=1000000). They never blank.
- Leading-zero blanking (blank_lz=1): digit k (k=3,2,1) is blanked when it and every more-significant digit equal 0. Digit 0 is never blanked.
- Blanked digit: an=0 and seg=0 for that slot; dp is also 0.
- dp: 1 only while digit DP_DIGIT is displayed and not blanked.
- Blink:
  - Frame counter counts wrap edges 0..BLINK_FRAMES-1. Each time it wraps, the phase bit toggles.
  - With blink_en=1 and phase=1, the whole display is off: an=0, seg=0, dp=0.
  - While blink_en=0, the counter and phase are held at 0, so enabling blink always starts with a full visible half-period.
- frame_done: 1 for exactly one cycle, coinciding with the edge where the index wraps 3→0.
- Mid-operation reset: all state returns to reset values immediately, asynchronously. Scanning restarts from index 0 on release.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2, DP_DIGIT=2):
- Reset, then load 16'h1234 → from the second frame, slots show an=0001 seg=1100110, an=0010 seg=1001111, an=0100 seg=1011011 dp=1, an=1000 seg=0000110. Each slot lasts 4 cycles; frame_done pulses every 16 cycles.
- Load 16'h0005 with blank_lz=1 → d3, d2, d1 slots have an=0 seg=0; d0 shows 1101101. With blank_lz=0, the same value shows 0111111 on d3..d1 and dp on d2.
- Load 16'h0000 with blank_lz=1 → only d0 is lit, seg=0111111. Load 16'h00A0 → d1 shows a dash 1000000; d3 and d2 are blanked.
- Load 16'h1111 during digit 1 of a frame, then 16'h2222 two cycles later → the rest of the current frame shows the old value; the next frame shows 2 on all digits. Load on the wrap cycle → applied one frame later.
- blink_en=1 with value 16'h0130 → 2 frames visible, 2 frames all-off (an=0), repeating. Dropping blink_en during an off phase → display is visible from the next slot edge.
- Assert rst_n=0 mid-slot while an=0100 → an, seg, dp and frame_done are 0 immediately, without waiting for a clock edge. After release, no output until 4 cycles, then index 1 with value 0.
